// File: rtl/link_anim_ctrl.sv
// Player sprite animation sequencer: facing/walk/attack FSM stepped once per frame,
// plus a two-stage pixel-to-ROM address pipeline aligned with a synchronous sprite ROM.
module link_anim_ctrl #(
    parameter int SPRITE_W      = 32,
    parameter int ANIM_DIV      = 8,
    parameter int ATTACK_FRAMES = 16
) (
    input  logic                             vga_clk,
    input  logic                             Reset,
    input  logic                             frame_start,
    input  logic [3:0]                       dir_req,
    input  logic                             attack_req,
    input  logic [9:0]                       link_x,
    input  logic [9:0]                       link_y,
    input  logic [9:0]                       DrawX,
    input  logic [9:0]                       DrawY,
    output logic [3:0]                       sprite_sel,
    output logic [2*$clog2(SPRITE_W)-1:0]    sprite_addr,
    output logic                             sprite_hit,
    output logic [1:0]                       facing,
    output logic                             attacking
);

    localparam int AW = $clog2(SPRITE_W);
    localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int KW = (ATTACK_FRAMES > 1) ? $clog2(ATTACK_FRAMES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WALK   = 2'd1,
        ATTACK = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [1:0]      facing_nx;
    logic            frame_bit, frame_bit_nx;
    logic [DW-1:0]   div_cnt, div_cnt_nx;
    logic [KW-1:0]   atk_cnt, atk_cnt_nx;
    logic [3:0]      sprite_sel_nx;
    logic            attacking_nx;
    logic [1:0]      dir_dec;
    logic            dir_any;

    // Priority up > down > left > right; bit 3 is up.
    always_comb begin
        dir_dec = 2'd3;
        if (dir_req[3])      dir_dec = 2'd0;
        else if (dir_req[2]) dir_dec = 2'd1;
        else if (dir_req[1]) dir_dec = 2'd2;
    end
    assign dir_any = |dir_req;

    always_comb begin
        // NOTE: every output of this block gets a hold/default value first so no latch is inferred.
        state_nx     = state;
        facing_nx    = facing;
        frame_bit_nx = frame_bit;
        div_cnt_nx   = div_cnt;
        atk_cnt_nx   = atk_cnt;
        if (frame_start) begin
            unique case (state)
                IDLE: begin
                    frame_bit_nx = 1'b0;
                    if (attack_req) begin
                        state_nx   = ATTACK;
                        atk_cnt_nx = '0;
                    end else if (dir_any) begin
                        state_nx   = WALK;
                        facing_nx  = dir_dec;
                        div_cnt_nx = '0;
                    end
                end
                WALK: begin
                    if (attack_req) begin
                        state_nx   = ATTACK;
                        atk_cnt_nx = '0;
                    end else if (!dir_any) begin
                        state_nx     = IDLE;
                        frame_bit_nx = 1'b0;
                        div_cnt_nx   = '0;
                    end else begin
                        facing_nx = dir_dec;
                        if (div_cnt == DW'(ANIM_DIV - 1)) begin
                            div_cnt_nx   = '0;
                            frame_bit_nx = ~frame_bit;
                        end else begin
                            div_cnt_nx = div_cnt + 1'b1;
                        end
                    end
                end
                ATTACK: begin
                    if (atk_cnt == KW'(ATTACK_FRAMES - 1)) begin
                        atk_cnt_nx   = '0;
                        frame_bit_nx = 1'b0;
                        if (dir_any) begin
                            state_nx   = WALK;
                            facing_nx  = dir_dec;
                            div_cnt_nx = '0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        atk_cnt_nx = atk_cnt + 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign attacking_nx  = (state_nx == ATTACK);
    assign sprite_sel_nx = attacking_nx ? {2'b10, facing_nx} : {1'b0, facing_nx, frame_bit_nx};

    always_ff @(posedge vga_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (Reset) begin
            state      <= IDLE;
            facing     <= 2'd1;
            frame_bit  <= 1'b0;
            div_cnt    <= '0;
            atk_cnt    <= '0;
            sprite_sel <= 4'd2;
            attacking  <= 1'b0;
        end else begin
            state      <= state_nx;
            facing     <= facing_nx;
            frame_bit  <= frame_bit_nx;
            div_cnt    <= div_cnt_nx;
            atk_cnt    <= atk_cnt_nx;
            if (frame_start) begin
                sprite_sel <= sprite_sel_nx;
                attacking  <= attacking_nx;
            end
        end
    end

    // Wrapping subtraction: pixels left of/above the sprite become large offsets and miss.
    logic [9:0] dx, dy;
    logic       in_box, hit_d1;

    assign dx     = DrawX - link_x;
    assign dy     = DrawY - link_y;
    assign in_box = (dx < 10'(SPRITE_W)) && (dy < 10'(SPRITE_W));

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            sprite_addr <= '0;
            hit_d1      <= 1'b0;
            sprite_hit  <= 1'b0;
        end else begin
            sprite_addr <= in_box ? {dy[AW-1:0], dx[AW-1:0]} : '0;
            hit_d1      <= in_box;
            sprite_hit  <= hit_d1;
        end
    end

endmodule
